// File: rtl/fft_output_reorder_buffer_if.sv
// Stream bundle for the FFT output reorder buffer: bit-reversed samples in,
// natural-order samples out, each side with its own valid/ready handshake.
interface fft_output_reorder_buffer_if #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [N-1:0] out_index;
  logic         out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/fft_output_reorder_buffer.sv
// Ping-pong reorder buffer: writes each frame at bit-reversed addresses and
// reads it back sequentially, so the output emerges in natural index order.
module fft_output_reorder_buffer #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fft_output_reorder_buffer_if.slave bus_io
);
  localparam int unsigned Depth = 2 ** N;

  logic [W-1:0] bank_q [2][Depth];

  logic         wr_bank_q, wr_bank_d;
  logic         rd_bank_q, rd_bank_d;
  logic [N-1:0] wr_cnt_q, wr_cnt_d;
  logic [N-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]   full_q, full_d;

  logic in_ready, out_valid, out_last;
  logic wr_en, rd_en, wr_last, rd_last;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] idx);
    logic [N-1:0] r;
    for (int unsigned i = 0; i < N; i++) begin
      r[i] = idx[N-1-i];
    end
    return r;
  endfunction

  // Flow control depends only on the full flags, never on out_ready.
  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_last  = out_valid & (rd_cnt_q == '1);

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid;
  assign bus_io.out_data  = bank_q[rd_bank_q][rd_cnt_q];
  assign bus_io.out_index = rd_cnt_q;
  assign bus_io.out_last  = out_last;

  always_comb begin
    wr_en     = bus_io.in_valid & in_ready;
    rd_en     = out_valid & bus_io.out_ready;
    wr_last   = wr_en & (wr_cnt_q == '1);
    rd_last   = rd_en & out_last;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;

    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + N'(1);
    end
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    if (rd_en) begin
      rd_cnt_d = rd_cnt_q + N'(1);
    end
    // Full gating keeps the two banks distinct, so both flag updates can coexist.
    if (rd_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      full_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_q[wr_bank_q][bitrev(wr_cnt_q)] <= bus_io.in_data;
    end
  end
endmodule
